truth_table_exerciser: RTL and testbench

- Synthesizable stimulus driver and response checker for the small combinational `top` blocks in the Binary Representations set, e.g. `top(A,B,C,F)`.
- On a start pulse it walks every input vector, from 0 up to 2^N_IN-1, onto the block under test.
- For each vector it waits a settle interval, samples F and compares it against a truth-table parameter.
- It counts mismatches, records the first failing vector, and reports pass/fail on-chip.
- It sits at the opposite end of the DUT interface: it drives A/B/C and consumes F.

---
 rtl/truth_table_pkg.sv | 18 +
 rtl/truth_table_exerciser_settle_timer.sv | 34 +++
 rtl/truth_table_exerciser.sv | 116 +++++++++++
 tb/tb_truth_table_exerciser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
`default_nettype none
// truth_table_pkg: shared state encoding and counter sizing for the truth-table exerciser.
// Revision: 1.0
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-cycle settle still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_exerciser_settle_timer.sv
`default_nettype none
// settle_timer: counts SETTLE enabled cycles per vector, pulsing last_o on the final one.
// Revision: 1.0
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int SETTLE = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_o
);

  localparam int            CW       = cnt_width(SETTLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;

  assign last_o = enable_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || last_o) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_exerciser.sv
`default_nettype none
// truth_table_exerciser: walks every input vector onto a combinational block and checks F.
// Revision: 1.0
module truth_table_exerciser
  import truth_table_pkg::*;
#(
  parameter int                    N_IN     = 3,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'b0100_0000,
  parameter int                    SETTLE   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] abc_out,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e          state_q;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   fail_q;
  logic [N_IN:0]   fail_d;
  logic            ffv_q;
  logic [N_IN-1:0] ffvec_q;

  logic            run;
  logic            start_ok;
  logic            last;
  logic            mismatch;

  assign run      = (state_q == RUN);
  assign start_ok = start && (state_q != RUN);
  assign mismatch = (f_in != EXPECTED[vec_q]);
  assign fail_d   = fail_q + {{N_IN{1'b0}}, mismatch};

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (start_ok),
    .enable_i (run),
    .last_o   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
          end
        end
        RUN: begin
          if (last) begin
            if (mismatch) begin
              fail_q <= fail_d;
              if (!ffv_q) begin
                ffv_q   <= 1'b1;
                ffvec_q <= vec_q;
              end
            end
            // Final vector: pass must include this cycle's sample, hence fail_d.
            if (vec_q == VEC_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_d == '0);
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign abc_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_exerciser.sv
`default_nettype none
// tb_truth_table_exerciser: two exercisers (SETTLE=5 and SETTLE=1) against behavioural DUT models.
// Revision: 1.0
`timescale 1ns/1ps
module tb_truth_table_exerciser;

  localparam logic [7:0] EXP = 8'b0100_0000;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0][2:0] abc;
  logic [1:0]      f;
  logic [1:0]      busy, done, pass, ffv;
  logic [1:0][3:0] fc;
  logic [1:0][2:0] ffvec;

  int mode = 0;
  logic [7:0] tt = 8'h00;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_exerciser #(.N_IN(3), .EXPECTED(EXP), .SETTLE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .abc_out(abc[0]), .f_in(f[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_count(fc[0]),
    .first_fail_valid(ffv[0]), .first_fail_vec(ffvec[0]));

  truth_table_exerciser #(.N_IN(3), .EXPECTED(EXP), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abc_out(abc[1]), .f_in(f[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_count(fc[1]),
    .first_fail_valid(ffv[1]), .first_fail_vec(ffvec[1]));

  // Block-under-test behaviours: 0 = A&B&~C, 1 = stuck-at-1, 2 = A&B, else table tt.
  function automatic logic dut_f(input int md, input logic [7:0] t, input logic [2:0] v);
    case (md)
      0:       return (v == 3'b110);
      1:       return 1'b1;
      2:       return v[2] & v[1];
      default: return t[v];
    endcase
  endfunction

  always_comb begin
    f[0] = dut_f(mode, tt, abc[0]);
    f[1] = dut_f(mode, tt, abc[1]);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: run position measured in cycles since the accepted start.
  int m_state[2];
  int m_k[2];
  int m_fc[2];
  int m_ffv[2];
  int m_ffvec[2];
  int ms, mv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] <= 0; m_k[i] <= 0; m_fc[i] <= 0; m_ffv[i] <= 0; m_ffvec[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        ms = (i == 0) ? 5 : 1;
        if (m_state[i] != 1) begin
          if (start) begin
            m_state[i] <= 1; m_k[i] <= 0; m_fc[i] <= 0; m_ffv[i] <= 0; m_ffvec[i] <= 0;
          end
        end else begin
          mv = m_k[i] / ms;
          if ((m_k[i] % ms) == ms - 1) begin
            if (dut_f(mode, tt, 3'(mv)) != EXP[mv]) begin
              m_fc[i] <= m_fc[i] + 1;
              if (m_ffv[i] == 0) begin
                m_ffv[i]   <= 1;
                m_ffvec[i] <= mv;
              end
            end
            if (mv == 7) m_state[i] <= 2;
          end
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ms = (i == 0) ? 5 : 1;
      chk($sformatf("busy%0d", i), int'(busy[i]), (m_state[i] == 1) ? 1 : 0);
      chk($sformatf("done%0d", i), int'(done[i]), (m_state[i] == 2) ? 1 : 0);
      chk($sformatf("abc%0d", i), int'(abc[i]),
          (m_state[i] == 1) ? (m_k[i] / ms) : ((m_state[i] == 2) ? 7 : 0));
      chk($sformatf("pass%0d", i), int'(pass[i]), (m_state[i] == 2 && m_fc[i] == 0) ? 1 : 0);
      chk($sformatf("fc%0d", i), int'(fc[i]), m_fc[i]);
      chk($sformatf("ffv%0d", i), int'(ffv[i]), m_ffv[i]);
      chk($sformatf("ffvec%0d", i), int'(ffvec[i]), m_ffvec[i]);
    end
  end

  // Busy run-length recorder, independent of the model.
  int rlen[2];
  int last_len[2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i]) rlen[i] <= rlen[i] + 1;
      else if (rlen[i] != 0) begin
        last_len[i] <= rlen[i];
        rlen[i]     <= 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_wait();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done == 2'b11) break;
    end
    chk("run_done", int'(done), 3);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_run(input int md, input logic [7:0] t);
    @(posedge clk); #1;
    mode = md; tt = t;
    pulse_start();
    run_wait();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_abc", int'(abc), 0);
    chk("reset_fc", int'(fc), 0);

    do_run(0, 8'h00);
    chk("ok_len5", last_len[0], 40);
    chk("ok_len1", last_len[1], 8);
    chk("ok_pass", int'(pass), 3);
    chk("ok_fc", int'(fc[0]), 0);
    chk("ok_ffv", int'(ffv), 0);

    do_run(1, 8'h00);
    chk("stuck_fc5", int'(fc[0]), 7);
    chk("stuck_fc1", int'(fc[1]), 7);
    chk("stuck_model_fc", m_fc[0], 7);
    chk("stuck_ffv", int'(ffv[0]), 1);
    chk("stuck_ffvec", int'(ffvec[0]), 0);
    chk("stuck_pass", int'(pass), 0);

    do_run(2, 8'h00);
    chk("ab_fc", int'(fc[0]), 1);
    chk("ab_ffvec", int'(ffvec[0]), 7);
    chk("ab_ffvec1", int'(ffvec[1]), 7);
    chk("ab_len", last_len[0], 40);

    // Restart from DONE after a failing run must clear results.
    do_run(0, 8'h00);
    chk("rerun_pass", int'(pass), 3);
    chk("rerun_fc", int'(fc[0]), 0);

    // Start pulsed mid-run is ignored by the SETTLE=5 instance.
    @(posedge clk); #1;
    mode = 2;
    pulse_start();
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_wait();
    chk("midstart_len", last_len[0], 40);
    chk("midstart_fc", int'(fc[0]), 1);

    // Asynchronous reset partway through a run.
    @(posedge clk); #1;
    mode = 0;
    pulse_start();
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_abc", int'(abc), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_fc", int'(fc), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_run(0, 8'h00);
    chk("post_rst_len", last_len[0], 40);
    chk("post_rst_pass", int'(pass), 3);

    // Random truth tables, optionally with a stray start during the run.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] t;
      int exp_first;
      t = 8'($urandom);
      exp_first = 0;
      for (int v = 7; v >= 0; v--) if (t[v] != EXP[v]) exp_first = v;
      @(posedge clk); #1;
      mode = 3; tt = t;
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      run_wait();
      chk("rnd_fc5", int'(fc[0]), $countones(t ^ EXP));
      chk("rnd_fc1", int'(fc[1]), $countones(t ^ EXP));
      chk("rnd_pass", int'(pass[0]), (t == EXP) ? 1 : 0);
      chk("rnd_ffvec", int'(ffvec[0]), exp_first);
      chk("rnd_len", last_len[0], 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
